// File: rtl/scan_ctrl.sv
// HUB75 scan/timing controller: shifts one row-plane, blanks, latches, then displays it
// for a binary-weighted time (BCM). All panel-facing outputs come from registered state.
module scan_ctrl #(
    parameter int unsigned SCAN_ROWS = 8,
    parameter int unsigned BITS      = 4,
    parameter int unsigned ON_BASE   = 8,
    localparam int unsigned ROW_W    = (SCAN_ROWS > 1) ? $clog2(SCAN_ROWS) : 1,
    localparam int unsigned PLANE_W  = (BITS > 1) ? $clog2(BITS) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               run_i,
    input  logic               colct_eq_max_i,
    output logic               colct_clr_o,
    output logic               colct_enb_o,
    output logic [PLANE_W-1:0] plane_o,
    output logic [ROW_W-1:0]   row_o,
    output logic               sclk_o,
    output logic               lat_o,
    output logic               oe_n_o,
    output logic [ROW_W-1:0]   row_addr_o,
    output logic               frame_done_o,
    output logic               busy_o
);

    // Wide enough to hold the longest on-time, ON_BASE << (BITS-1).
    localparam int unsigned CNT_W = $clog2((ON_BASE << (BITS - 1)) + 1);

    typedef enum logic [2:0] {
        StIdle,
        StShiftLo,
        StShiftHi,
        StBlank,
        StLatch,
        StDisplay
    } state_e;

    state_e             state_q, state_d;
    logic [PLANE_W-1:0] plane_q, plane_d;
    logic [ROW_W-1:0]   row_q, row_d;
    logic [ROW_W-1:0]   row_addr_q, row_addr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               frame_done_q, frame_done_d;
    logic               last_plane;
    logic               last_row;

    assign last_plane = (plane_q == PLANE_W'(BITS - 1));
    assign last_row   = (row_q == ROW_W'(SCAN_ROWS - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            plane_q      <= '0;
            row_q        <= '0;
            row_addr_q   <= '0;
            cnt_q        <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            plane_q      <= plane_d;
            row_q        <= row_d;
            row_addr_q   <= row_addr_d;
            cnt_q        <= cnt_d;
            frame_done_q <= frame_done_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        plane_d      = plane_q;
        row_d        = row_q;
        row_addr_d   = row_addr_q;
        cnt_d        = cnt_q;
        frame_done_d = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (run_i) begin
                    state_d = StShiftLo;
                end
            end
            StShiftLo: begin
                state_d = StShiftHi;
            end
            StShiftHi: begin
                state_d = colct_eq_max_i ? StBlank : StShiftLo;
            end
            StBlank: begin
                state_d = StLatch;
            end
            StLatch: begin
                row_addr_d = row_q;
                cnt_d      = CNT_W'((ON_BASE << plane_q) - 1);
                state_d    = StDisplay;
            end
            StDisplay: begin
                if (cnt_q == '0) begin
                    state_d = StShiftLo;
                    if (!last_plane) begin
                        plane_d = plane_q + PLANE_W'(1);
                    end else begin
                        plane_d = '0;
                        if (!last_row) begin
                            row_d = row_q + ROW_W'(1);
                        end else begin
                            // Frame wrap: the only point besides idle where run is honoured.
                            row_d        = '0;
                            frame_done_d = 1'b1;
                            if (!run_i) begin
                                state_d = StIdle;
                            end
                        end
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_comb begin
        sclk_o       = (state_q == StShiftHi);
        lat_o        = (state_q == StLatch);
        oe_n_o       = (state_q != StDisplay);
        busy_o       = (state_q != StIdle);
        colct_enb_o  = (state_q == StShiftHi);
        // Clear on the last column shift; the counter gives clear priority over enable.
        colct_clr_o  = (state_q == StIdle) || ((state_q == StShiftHi) && colct_eq_max_i);
        plane_o      = plane_q;
        row_o        = row_q;
        row_addr_o   = row_addr_q;
        frame_done_o = frame_done_q;
    end

endmodule

// File: tb/tb_scan_ctrl.sv
// Scoreboard bench for scan_ctrl with a behavioural 32-column counter attached.
module tb_scan_ctrl;

    localparam int ON_BASE = 8;
    localparam int FRAME   = 3072;

    logic       clk = 1'b0;
    logic       rst;
    logic       run;
    logic       colct_eq_max;
    logic       colct_clr;
    logic       colct_enb;
    logic [1:0] plane;
    logic [2:0] row;
    logic       sclk;
    logic       lat;
    logic       oe_n;
    logic [2:0] row_addr;
    logic       frame_done;
    logic       busy;
    logic [5:0] col;

    scan_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .run_i          (run),
        .colct_eq_max_i (colct_eq_max),
        .colct_clr_o    (colct_clr),
        .colct_enb_o    (colct_enb),
        .plane_o        (plane),
        .row_o          (row),
        .sclk_o         (sclk),
        .lat_o          (lat),
        .oe_n_o         (oe_n),
        .row_addr_o     (row_addr),
        .frame_done_o   (frame_done),
        .busy_o         (busy)
    );

    always #5 clk = ~clk;

    always_ff @(posedge clk) begin
        if (rst || colct_clr) col <= '0;
        else if (colct_enb)   col <= col + 6'd1;
    end
    assign colct_eq_max = (col == 6'd31);

    typedef struct {
        int row;
        int plane;
        int len;
    } disp_t;

    disp_t       disp_q[$];
    int          fd_q[$];
    logic [20:0] idle_q[$];

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [20:0] mk_idle(input logic [2:0] ra, input logic fd);
        return {1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, fd, 2'd0, 3'd0, ra, 6'd0};
    endfunction

    function automatic logic [20:0] snap();
        return {busy, oe_n, sclk, lat, colct_clr, colct_enb, frame_done, plane, row, row_addr, col};
    endfunction

    // Monitor state
    int       cyc = 0, t0 = 0, run_rise = 0, last_hi = 0;
    int       sclk_cnt = 0, lat_sclk = 0, lat_row = 0, lat_plane = 0, oe_cnt = 0;
    logic     addr_bad = 1'b0;
    logic     prev_rst = 1'b1, prev_busy = 1'b0, prev_oe = 1'b1, prev_lat = 1'b0;
    logic     prev_sclk = 1'b0, prev_fd = 1'b0, prev_run = 1'b0;
    logic [2:0] prev_row_addr = 3'd0;

    always @(negedge clk) begin
        disp_t d;
        logic [20:0] e;
        cyc++;
        if (rst) begin
            disp_q.delete();
            fd_q.delete();
            sclk_cnt = 0;
            oe_cnt   = 0;
            addr_bad = 1'b0;
        end else begin
            if (prev_rst || (prev_busy && !busy)) begin
                if (idle_q.size() == 0) check("idle_underflow", 1, 0);
                else begin
                    e = idle_q.pop_front();
                    check("idle_snapshot", int'(snap()), int'(e));
                end
            end
            if (!prev_busy && busy && !prev_rst) begin
                check("start_latency", cyc - run_rise, 1);
                t0 = cyc;
            end
            check("col_in_range", int'(col < 6'd32), 1);
            check("enb_only_shift_hi", int'(colct_enb), int'(sclk));
            check("clr_decode", int'(colct_clr), int'(!busy || (sclk && colct_eq_max)));
            if (sclk) begin
                check("sclk_alternates", int'(prev_sclk), 0);
                check("col_step", int'(col), sclk_cnt);
                sclk_cnt++;
                last_hi = cyc;
            end
            if (lat) begin
                check("col_zero_at_latch", int'(col), 0);
                check("latch_gap", cyc - last_hi, 2);
                lat_row   = int'(row);
                lat_plane = int'(plane);
                lat_sclk  = sclk_cnt;
                sclk_cnt  = 0;
            end
            if (prev_lat) check("lat_width", int'(lat), 0);
            if (row_addr != prev_row_addr && !prev_rst)
                check("row_addr_after_latch", int'(prev_lat), 1);
            if (!oe_n) begin
                if (prev_oe) begin
                    check("display_after_latch", int'(prev_lat), 1);
                    oe_cnt   = 0;
                    addr_bad = 1'b0;
                end
                oe_cnt++;
                if (int'(row_addr) != lat_row) addr_bad = 1'b1;
            end
            if (oe_n && !prev_oe) begin
                if (disp_q.size() == 0) check("disp_underflow", 1, 0);
                else begin
                    d = disp_q.pop_front();
                    check("disp_row", lat_row, d.row);
                    check("disp_plane", lat_plane, d.plane);
                    check("disp_len", oe_cnt, d.len);
                    check("sclk_pulses", lat_sclk, 32);
                    check("row_addr_stable", int'(addr_bad), 0);
                end
            end
            if (frame_done) begin
                if (fd_q.size() == 0) check("fd_underflow", 1, 0);
                else check("frame_done_time", cyc - t0, fd_q.pop_front());
                check("wrap_pos", int'({plane, row, row_addr}), int'({2'd0, 3'd0, 3'd7}));
            end
            if (prev_fd) check("frame_done_width", int'(frame_done), 0);
        end
        if (!prev_run && run) run_rise = cyc;
        prev_rst      = rst;
        prev_busy     = busy;
        prev_oe       = rst ? 1'b1 : oe_n;
        prev_lat      = rst ? 1'b0 : lat;
        prev_sclk     = sclk;
        prev_fd       = frame_done;
        prev_run      = run;
        prev_row_addr = row_addr;
    end

    task automatic push_frame();
        for (int r = 0; r < 8; r++)
            for (int p = 0; p < 4; p++)
                disp_q.push_back('{row: r, plane: p, len: ON_BASE << p});
    endtask

    initial begin
        int n;
        logic done;
        rst = 1'b1;
        run = 1'b0;
        repeat (3) @(posedge clk);
        idle_q.push_back(mk_idle(3'd0, 1'b0));
        #1 rst = 1'b0;

        // Three frames, run dropped in row 3 of the third
        @(posedge clk); #1;
        for (int f = 0; f < 3; f++) push_frame();
        fd_q.push_back(FRAME);
        fd_q.push_back(2 * FRAME);
        fd_q.push_back(3 * FRAME);
        idle_q.push_back(mk_idle(3'd7, 1'b1));
        run = 1'b1;
        repeat (2 * FRAME + 3 * 384 + 100) @(posedge clk);
        #1 run = 1'b0;
        done = 1'b0;
        for (int i = 0; i < 4000 && !done; i++) begin
            @(posedge clk); #1;
            if (!busy) done = 1'b1;
        end
        if (!done) check("timeout_run_drop", 0, 1);

        // Reset during DISPLAY
        repeat (2) @(posedge clk); #1;
        push_frame();
        run = 1'b1;
        done = 1'b0;
        for (int i = 0; i < 200 && !done; i++) begin
            @(posedge clk); #1;
            if (!oe_n) done = 1'b1;
        end
        if (!done) check("timeout_display", 0, 1);
        repeat (3) @(posedge clk); #1;
        idle_q.push_back(mk_idle(3'd0, 1'b0));
        rst = 1'b1;
        run = 1'b0;
        @(posedge clk); #1 rst = 1'b0;

        // Reset during SHIFT_HI
        repeat (2) @(posedge clk); #1;
        push_frame();
        run = 1'b1;
        n = 0;
        for (int i = 0; i < 200 && n < 4; i++) begin
            @(posedge clk); #1;
            if (sclk) n++;
        end
        if (n < 4) check("timeout_shift", 0, 1);
        idle_q.push_back(mk_idle(3'd0, 1'b0));
        rst = 1'b1;
        run = 1'b0;
        @(posedge clk); #1 rst = 1'b0;

        repeat (4) @(posedge clk); #1;
        check("disp_leftover", disp_q.size(), 0);
        check("fd_leftover", fd_q.size(), 0);
        check("idle_leftover", idle_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/scan_ctrl.md
Name: scan_ctrl

Overview:
- Scan/timing FSM for the 32x16 HUB75 LED matrix controller.
- Drives the column counter via colct_clr/colct_enb, consumes colct_eq_max, and generates panel shift clock, latch, output-enable and row address.
- Implements binary-coded-modulation (BCM) brightness over BITS bit-planes, non-overlapped: shift -> blank -> latch -> display.
- Sits between the frame-buffer read logic (fed by plane/row/col) and the panel pins.

Parameters:
- SCAN_ROWS, 8, row pairs addressed per scan (1/8 scan); ROW_W = $clog2(SCAN_ROWS).
- BITS, 4, bit-planes per colour; PLANE_W = max(1, $clog2(BITS)).
- ON_BASE, 8, display cycles for plane 0; plane p displays ON_BASE<<p cycles.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- run  in  1  level; 1 = scan frames continuously
- colct_eq_max  in  1  from column counter, column == last column
- colct_clr  out  1  column counter clear
- colct_enb  out  1  column counter increment
- plane  out  PLANE_W  bit-plane being shifted (frame-buffer address)
- row  out  ROW_W  row being shifted (frame-buffer address)
- sclk  out  1  panel shift clock
- lat  out  1  panel latch strobe
- oe_n  out  1  panel output enable, active-low
- row_addr  out  ROW_W  panel A/B/C row select (displayed row)
- frame_done  out  1  one-cycle pulse at end of each full frame
- busy  out  1  1 whenever state != IDLE

Behaviour:
- All outputs registered or decoded from the registered state. No combinational path from run or colct_eq_max to sclk, lat, oe_n or row_addr.
- Reset (any state): state = IDLE, plane = 0, row = 0, row_addr = 0, display counter = 0, sclk = 0, lat = 0, oe_n = 1, frame_done = 0, colct_enb = 0, colct_clr = 1.
- IDLE:
  - colct_clr = 1, oe_n = 1.
  - run = 1 -> SHIFT_LO next cycle.
- SHIFT_LO:
  - sclk = 0.
  - Pixel data for (plane, row, col) must be stable at the panel this cycle.
  - -> SHIFT_HI.
- SHIFT_HI:
  - sclk = 1, colct_enb = 1.
  - If colct_eq_max = 1: also colct_clr = 1 (clear dominates in the counter) and -> BLANK.
  - Else -> SHIFT_LO.
  - One row-plane shift therefore takes 64 cycles for 32 columns.
- BLANK:
  - Exactly 1 cycle, oe_n = 1.
  - -> LATCH.
- LATCH:
  - Exactly 1 cycle, lat = 1.
  - row_addr <= row (takes effect the next cycle).
  - Display counter loaded with (ON_BASE<<plane) - 1.
  - -> DISPLAY.
- DISPLAY:
  - oe_n = 0 for exactly ON_BASE<<plane cycles, counting down to 0.
  - On the final cycle, advance plane/row:
    - plane < BITS-1: plane++.
    - Otherwise plane = 0 and row++.
    - row == SCAN_ROWS-1 wrapping to 0: frame_done = 1 next cycle (one-cycle pulse).
  - Next state: on a frame wrap with run = 0 -> IDLE; otherwise -> SHIFT_LO.
- run is sampled only in IDLE and at frame wrap. Deasserting run mid-frame completes the frame.
- oe_n = 1 in every state except DISPLAY; lat = 1 only in LATCH; sclk = 1 only in SHIFT_HI.
- colct_enb = 0 outside SHIFT_HI; colct_clr = 0 except in IDLE and at the last SHIFT_HI.
- Display counter width: enough for ON_BASE<<(BITS-1). With defaults that is 64, so 7 bits.
- Cycles per row-plane (default): 64 + 1 + 1 + 8·2^p. Per frame: 8 rows × Σp = 8·(264+120) = 3072 cycles.

Test Plan:
- Reset then run = 1 for 1 frame:
  - IDLE -> SHIFT_LO after 1 cycle.
  - 32 sclk pulses, sclk high every other cycle.
  - lat high exactly 1 cycle, 1 cycle after the last sclk fall.
  - oe_n low 8 cycles for plane 0.
- BCM timing: over one row, oe_n low runs measure 8, 16, 32, 64 cycles for planes 0..3; row_addr changes only the cycle after a LATCH.
- Frame wrap: after 3072 cycles from first SHIFT_LO, frame_done pulses once. row returns to 0, row_addr = 7 until the next LATCH.
- run dropped mid-frame (row 3): the frame completes through row 7 plane 3, then IDLE with oe_n = 1, busy = 0, colct_clr = 1.
- rst asserted during DISPLAY and during SHIFT_HI: the next cycle shows IDLE with oe_n = 1, sclk = 0, lat = 0, plane = row = row_addr = 0. With a colctr instance attached, col = 0.
- Integration with colctr (NUM_PANELS = 1):
  - col steps 0..31 across SHIFT_HI cycles.
  - colct_eq_max at col 31 causes exactly one transition to BLANK.
  - col = 0 at BLANK; col never reaches 32.
